// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-detect inputs, pipeline register controls and perf counters
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic ID_useRs1;
    logic ID_useRs2;
    logic EX_MemRead;
    logic [4:0] EX_rd;
    logic EX_redirect;
    logic imem_ready;
    logic dmem_busy;
    logic PCWrite;
    logic PCSel;
    logic IF_IDWrite;
    logic IF_IDFlush;
    logic ID_EXWrite;
    logic ID_EXFlush;
    logic EX_MEMWrite;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output ID_rs1, ID_rs2, ID_useRs1, ID_useRs2, EX_MemRead, EX_rd, EX_redirect, imem_ready, dmem_busy,
        input PCWrite, PCSel, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush, EX_MEMWrite, stall_cnt, flush_cnt
    );
    modport slave (
        input ID_rs1, ID_rs2, ID_useRs1, ID_useRs2, EX_MemRead, EX_rd, EX_redirect, imem_ready, dmem_busy,
        output PCWrite, PCSel, IF_IDWrite, IF_IDFlush, ID_EXWrite, ID_EXFlush, EX_MEMWrite, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with saturating perf counters
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int REDIRECT_CYCLES = 1,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, LUSTALL, REDIR} state_t;
    state_t state, nxt;
    logic [3:0] rem, nrem;
    logic hazard, redir_go;
    logic [CNT_W-1:0] stall_q, flush_q;
    assign hazard = hz.EX_MemRead && hz.EX_rd != 5'd0 &&
                    ((hz.ID_useRs1 && hz.ID_rs1 == hz.EX_rd) || (hz.ID_useRs2 && hz.ID_rs2 == hz.EX_rd));
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
    always_comb begin
        nxt = state;
        nrem = rem;
        redir_go = 1'b0;
        hz.PCWrite = 1'b1;
        hz.PCSel = 1'b0;
        hz.IF_IDWrite = 1'b1;
        hz.IF_IDFlush = 1'b0;
        hz.ID_EXWrite = 1'b1;
        hz.ID_EXFlush = 1'b0;
        hz.EX_MEMWrite = 1'b1;
        if (reset) begin
            hz.PCWrite = 1'b0;
            hz.IF_IDWrite = 1'b0;
            hz.ID_EXWrite = 1'b0;
            hz.EX_MEMWrite = 1'b0;
            hz.IF_IDFlush = 1'b1;
            hz.ID_EXFlush = 1'b1;
        end else if (hz.dmem_busy) begin
            // whole pipe freezes; a pending redirect stays on its input until busy drops
            hz.PCWrite = 1'b0;
            hz.IF_IDWrite = 1'b0;
            hz.ID_EXWrite = 1'b0;
            hz.EX_MEMWrite = 1'b0;
        end else if (state == REDIR) begin
            hz.IF_IDFlush = 1'b1;
            nrem = rem - 4'd1;
            nxt = rem <= 4'd1 ? RUN : REDIR;
        end else if (state == LUSTALL) begin
            hz.PCWrite = 1'b0;
            hz.IF_IDWrite = 1'b0;
            hz.ID_EXFlush = 1'b1;
            nrem = rem - 4'd1;
            nxt = rem <= 4'd1 ? RUN : LUSTALL;
        end else if (hz.EX_redirect) begin
            redir_go = 1'b1;
            hz.PCSel = 1'b1;
            hz.IF_IDFlush = 1'b1;
            hz.ID_EXFlush = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
                nxt = REDIR;
                nrem = 4'(REDIRECT_CYCLES - 1);
            end
        end else if (hazard) begin
            hz.PCWrite = 1'b0;
            hz.IF_IDWrite = 1'b0;
            hz.ID_EXFlush = 1'b1;
            if (LOAD_STALL > 1) begin
                nxt = LUSTALL;
                nrem = 4'(LOAD_STALL - 1);
            end
        end else if (!hz.imem_ready) begin
            hz.PCWrite = 1'b0;
            hz.IF_IDFlush = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            rem <= 4'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state <= nxt;
            rem <= nrem;
            if (!hz.PCWrite && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
            if (redir_go && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
        end
    end
endmodule
